// File: rtl/gf_inv_4_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : gf_inv_4_seq_if
// Description : Operand/result handshake bundle for the sequential GF(2^4)
//               inverter. The master drives operands and accepts results.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
interface gf_inv_4_seq_if;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface
`default_nettype wire

// File: rtl/gf_inv_4_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : gf_inv_4_seq
// Description : Multi-cycle GF(2^4) inverter over GF(2^2) normal basis.
//               A single GF(2^2) multiplier is time-shared across three
//               compute states (S1: a*b, S2: d*b, S3: d*a).
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module gf_inv_4_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  gf_inv_4_seq_if.slave    bus,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    DONE = 3'd4
  } state_t;

  // GF(2^2) multiply in normal basis [Omega^2, Omega]
  function automatic logic [1:0] mul2(input logic [1:0] x, input logic [1:0] y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction

  // Squaring, which in GF(2^2) is also inversion
  function automatic logic [1:0] sq2(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

  // Square followed by scaling with the tower-field constant
  function automatic logic [1:0] sqscl2(input logic [1:0] x);
    return {x[1] ^ x[0], x[0]};
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_a;
  logic [1:0]       r_b;
  logic [1:0]       r_d;
  logic [3:0]       r_q;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_handoff;
  logic [1:0]       w_mx;
  logic [1:0]       w_my;
  logic [1:0]       w_prod;
  logic [1:0]       w_c;

  assign w_in_ready = (r_state == IDLE) | ((r_state == DONE) & bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_handoff  = r_out_valid & bus.out_ready;

  // Steer the shared multiplier operands according to the compute phase
  always_comb begin
    w_mx = r_a;
    w_my = r_b;
    case (r_state)
      S2:      begin w_mx = r_d; w_my = r_b; end
      S3:      begin w_mx = r_d; w_my = r_a; end
      default: begin w_mx = r_a; w_my = r_b; end
    endcase
  end

  // The one and only GF(2^2) multiplier
  assign w_prod = mul2(w_mx, w_my);
  assign w_c    = w_prod ^ sqscl2(r_a ^ r_b);

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = S1;
      S1:   w_state_nxt = S2;
      S2:   w_state_nxt = S3;
      S3:   w_state_nxt = DONE;
      DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = bus.in_valid ? S1 : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, operand and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= 2'b00;
      r_b         <= 2'b00;
      r_d         <= 2'b00;
      r_q         <= 4'b0000;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt == DONE);
      if (w_accept) begin
        r_a <= bus.in_data[3:2];
        r_b <= bus.in_data[1:0];
      end
      if (r_state == S1) r_d <= sq2(w_c);
      if (r_state == S2) r_q[3:2] <= w_prod;
      if (r_state == S3) r_q[1:0] <= w_prod;
    end
  end

  // Completed-handoff counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_handoff) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_q;
  assign busy          = (r_state == S1) | (r_state == S2) | (r_state == S3);
  assign ops_done      = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gf_inv_4_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_gf_inv_4_seq
// Description : Directed self-checking bench for gf_inv_4_seq.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gf_inv_4_seq;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [7:0] ops_done;
  logic       busy2;
  logic [1:0] ops_done2;

  int         checks;
  int         errors;
  logic [7:0] exp_ops;

  // Hand-derived GF(2^4) inverse table in this encoding
  logic [3:0] inv_tab [16];

  gf_inv_4_seq_if u_if ();
  gf_inv_4_seq_if u_if2 ();

  gf_inv_4_seq #(.CNT_W(8)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (u_if),
    .busy     (busy),
    .ops_done (ops_done)
  );

  gf_inv_4_seq #(.CNT_W(2)) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (u_if2),
    .busy     (busy2),
    .ops_done (ops_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one operand from IDLE and wait for its result (no handoff)
  task automatic run_op(input logic [3:0] a, output logic [3:0] q,
                        output int edges, output int waits);
    u_if.out_ready = 1'b0;
    u_if.in_valid  = 1'b1;
    u_if.in_data   = a;
    waits = 0;
    while (!u_if.in_ready && waits < 20) begin
      tick();
      waits++;
    end
    tick();
    u_if.in_valid = 1'b0;
    edges = 1;
    while (!u_if.out_valid && edges < 12) begin
      tick();
      edges++;
    end
    q = u_if.out_data;
  endtask

  task automatic handoff;
    u_if.out_ready = 1'b1;
    tick();
    u_if.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", u_if.out_valid); end
    checks++; if (u_if.out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", u_if.out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (ops_done !== 8'd0) begin errors++; $display("FAIL reset_ops_done got %0d want 0", ops_done); end
    checks++; if (u_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", u_if.in_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_ops = 8'd0;
  endtask

  task automatic test_basic;
    logic [3:0] q;
    int edges, waits;
    run_op(4'hF, q, edges, waits);
    checks++; if (waits != 0) begin errors++; $display("FAIL first_accept_wait got %0d want 0", waits); end
    checks++; if (edges != 4) begin errors++; $display("FAIL basic_latency got %0d want 4", edges); end
    checks++; if (q !== 4'hF) begin errors++; $display("FAIL basic_data got %h want f", q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got %b want 0", busy); end
    handoff();
    exp_ops++;
    checks++; if (ops_done !== exp_ops) begin errors++; $display("FAIL basic_ops_done got %0d want %0d", ops_done, exp_ops); end
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", u_if.out_valid); end
  endtask

  task automatic test_vectors;
    logic [3:0] vin  [4] = '{4'hC, 4'h2, 4'h3, 4'h0};
    logic [3:0] vexp [4] = '{4'h2, 4'hC, 4'h8, 4'h0};
    logic [3:0] q;
    int edges, waits;
    for (int i = 0; i < 4; i++) begin
      run_op(vin[i], q, edges, waits);
      checks++; if (q !== vexp[i]) begin errors++; $display("FAIL vec_data in=%h got %h want %h", vin[i], q, vexp[i]); end
      checks++; if (edges != 4) begin errors++; $display("FAIL vec_latency in=%h got %0d want 4", vin[i], edges); end
      handoff();
      exp_ops++;
      checks++; if (ops_done !== exp_ops) begin errors++; $display("FAIL vec_ops_done got %0d want %0d", ops_done, exp_ops); end
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] q;
    int edges, waits;
    run_op(4'h6, q, edges, waits);
    checks++; if (q !== 4'hE) begin errors++; $display("FAIL bp_data got %h want e", q); end
    u_if.in_valid = 1'b1;
    u_if.in_data  = 4'h5;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (u_if.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc=%0d got %b want 1", i, u_if.out_valid); end
      checks++; if (u_if.out_data !== 4'hE) begin errors++; $display("FAIL bp_hold_data cyc=%0d got %h want e", i, u_if.out_data); end
      checks++; if (u_if.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got %b want 0", i, u_if.in_ready); end
      checks++; if (ops_done !== exp_ops) begin errors++; $display("FAIL bp_ops_hold cyc=%0d got %0d want %0d", i, ops_done, exp_ops); end
    end
    u_if.in_valid = 1'b0;
    handoff();
    exp_ops++;
    checks++; if (ops_done !== exp_ops) begin errors++; $display("FAIL bp_ops_done got %0d want %0d", ops_done, exp_ops); end
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got %b want 0", u_if.out_valid); end
  endtask

  task automatic test_back_to_back;
    int  k, r, cyc, last_acc;
    bit  rdy;
    k = 0; r = 0; cyc = 0; last_acc = -1;
    u_if.out_ready = 1'b1;
    u_if.in_valid  = 1'b1;
    u_if.in_data   = 4'h0;
    while (r < 16 && cyc < 300) begin
      rdy = u_if.in_ready && u_if.in_valid;
      if (u_if.out_valid) begin
        checks++; if (u_if.out_data !== inv_tab[r]) begin errors++; $display("FAIL b2b_data in=%0d got %h want %h", r, u_if.out_data, inv_tab[r]); end
        checks++; if (inv_tab[u_if.out_data] !== 4'(r)) begin errors++; $display("FAIL b2b_inverse in=%0d got %h want %h", r, inv_tab[u_if.out_data], 4'(r)); end
        r++;
      end
      tick();
      cyc++;
      if (rdy) begin
        if (last_acc >= 0) begin
          checks++; if (cyc - last_acc != 4) begin errors++; $display("FAIL b2b_spacing got %0d want 4", cyc - last_acc); end
        end
        last_acc = cyc;
        k++;
        if (k == 16) u_if.in_valid = 1'b0;
        else         u_if.in_data  = 4'(k);
      end
    end
    checks++; if (r != 16) begin errors++; $display("FAIL b2b_timeout got %0d want 16", r); end
    u_if.out_ready = 1'b0;
    u_if.in_valid  = 1'b0;
    exp_ops = exp_ops + 8'd16;
    checks++; if (ops_done !== exp_ops) begin errors++; $display("FAIL b2b_ops_done got %0d want %0d", ops_done, exp_ops); end
  endtask

  task automatic test_reset_mid;
    logic [3:0] q;
    int edges, waits;
    bit seen;
    u_if.out_ready = 1'b0;
    u_if.in_valid  = 1'b1;
    u_if.in_data   = 4'h5;
    tick();
    u_if.in_valid = 1'b0;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got %b want 1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (u_if.out_data !== 4'h0) begin errors++; $display("FAIL mid_out_data got %h want 0", u_if.out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    checks++; if (ops_done !== 8'd0) begin errors++; $display("FAIL mid_ops_done got %0d want 0", ops_done); end
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", u_if.out_valid); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_ops = 8'd0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (u_if.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_stale_valid got %b want 0", seen); end
    run_op(4'hF, q, edges, waits);
    checks++; if (q !== 4'hF) begin errors++; $display("FAIL mid_next_data got %h want f", q); end
    checks++; if (edges != 4) begin errors++; $display("FAIL mid_next_latency got %0d want 4", edges); end
    handoff();
    exp_ops++;
    checks++; if (ops_done !== exp_ops) begin errors++; $display("FAIL mid_next_ops got %0d want %0d", ops_done, exp_ops); end
  endtask

  task automatic test_cnt_wrap;
    logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int g;
    checks++; if (ops_done2 !== 2'd0) begin errors++; $display("FAIL wrap_start got %0d want 0", ops_done2); end
    for (int i = 0; i < 5; i++) begin
      u_if2.in_valid = 1'b1;
      u_if2.in_data  = 4'(i + 1);
      g = 0;
      while (!u_if2.in_ready && g < 20) begin tick(); g++; end
      tick();
      u_if2.in_valid = 1'b0;
      g = 0;
      while (!u_if2.out_valid && g < 12) begin tick(); g++; end
      checks++; if (u_if2.out_data !== inv_tab[i + 1]) begin errors++; $display("FAIL wrap_data op=%0d got %h want %h", i, u_if2.out_data, inv_tab[i + 1]); end
      u_if2.out_ready = 1'b1;
      tick();
      u_if2.out_ready = 1'b0;
      checks++; if (ops_done2 !== want[i]) begin errors++; $display("FAIL wrap_count op=%0d got %0d want %0d", i, ops_done2, want[i]); end
    end
  endtask

  initial begin
    inv_tab = '{4'h0, 4'h4, 4'hC, 4'h8, 4'h1, 4'hA, 4'hE, 4'hD,
                4'h3, 4'hB, 4'h5, 4'h9, 4'h2, 4'h7, 4'h6, 4'hF};
    checks          = 0;
    errors          = 0;
    exp_ops         = 8'd0;
    u_if.in_valid   = 1'b0;
    u_if.in_data    = 4'h0;
    u_if.out_ready  = 1'b0;
    u_if2.in_valid  = 1'b0;
    u_if2.in_data   = 4'h0;
    u_if2.out_ready = 1'b0;
    rst_n           = 1'b1;

    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_cnt_wrap();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gf_inv_4_seq.md
GF_INV_4_SEQ -- requirements
Module: gf_inv_4_seq

Interface
REQ-001 Parameter: CNT_W, default 8, width of the completed-operation counter.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  operand A present.
REQ-005 Port: in_data  input  4  operand A in GF(2^4): [3:2] = high coordinate a, [1:0] = low coordinate b. Both coordinates are GF(2^2) values in normal basis [Omega^2, Omega].
REQ-006 Port: in_ready  output  1  block can accept an operand this cycle.
REQ-007 Port: out_valid  output  1  result held on out_data.
REQ-008 Port: out_data  output  4  result Q = A^-1, same encoding as in_data.
REQ-009 Port: out_ready  input  1  consumer takes the result this cycle.
REQ-010 Port: busy  output  1  high in S1, S2, S3.
REQ-011 Port: ops_done  output  CNT_W  count of results handed off.

Function
REQ-012 GF(2^2) primitives are defined as follows.
- mul2(X,Y): e = (X1^X0)&(Y1^Y0); result {X1&Y1 ^ e, X0&Y0 ^ e}.
- sq2(X) = {X0, X1}; this is also the GF(2^2) inverse.
- sqscl2(X) = {X1^X0, X0}.
REQ-013 Math: c = mul2(a,b) ^ sqscl2(a^b); d = sq2(c); Q[3:2] = mul2(d,b); Q[1:0] = mul2(d,a).
REQ-014 Exactly one mul2 instance exists; it is time-shared by the FSM. One sq2 and one sqscl2 instance are permitted.
REQ-015 FSM states are IDLE, S1, S2, S3, DONE. After reset the state is IDLE.
REQ-016 Transfer rules:
- Input transfer occurs on a rising edge with in_valid & in_ready.
- in_ready = (state==IDLE) | (state==DONE & out_ready), combinational.
- On input transfer, in_data is latched into the operand registers a and b.
REQ-017 Transitions:
- IDLE -> S1 on input transfer.
- S1: mul2(a,b) is computed, d register <= sq2(c); -> S2.
- S2: mul2(d,b) -> out_data[3:2] register; -> S3.
- S3: mul2(d,a) -> out_data[1:0] register; -> DONE.
REQ-018 DONE:
- out_valid = 1.
- On out_ready with in_valid: new operand latched, -> S1 (back-to-back).
- On out_ready without in_valid: -> IDLE.
- Otherwise remain in DONE.
REQ-019 Latency: out_valid rises 4 edges after the accepting edge. Back-to-back sustained throughput is 1 result per 4 cycles.
REQ-020 out_data and out_valid are registered and stable throughout DONE; out_data changes only in S2/S3.
REQ-021 in_valid and in_data are ignored outside IDLE and DONE.
REQ-022 ops_done increments by 1 on each edge with out_valid & out_ready, and wraps from 2^CNT_W-1 to 0.
REQ-023 Input 4'b0000 yields 4'b0000 with no special-casing; it follows the same 4-cycle path.

Reset
REQ-024 On rst_n low, immediately and regardless of clk: state=IDLE, out_valid=0, busy=0, out_data=0, ops_done=0, a=b=d=0.
REQ-025 Reset asserted in any state, including mid S1-S3 or DONE, discards the operation in flight; no result is produced for it.
REQ-026 First input transfer is possible on the first rising edge after rst_n deasserts.

Verification
REQ-027 Reset, then in_data=4'b1111 with out_ready=1 -> out_valid 4 edges later with out_data=4'b1111; ops_done=1.
REQ-028 in_data=4'b1100 -> out_data=4'b0010; in_data=4'b0010 -> 4'b1100; in_data=4'b0011 -> 4'b1000; in_data=4'b0000 -> 4'b0000.
REQ-029 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_data held, in_ready=0, ops_done unchanged; then out_ready=1 -> handoff, ops_done+1.
REQ-030 Back-to-back: in_valid=1 continuously with out_ready=1 -> in_ready pulses once per 4 cycles; all 16 inputs produce Q such that inverse(Q)=A; ops_done=16.
REQ-031 rst_n pulsed low during S2 -> outputs zero asynchronously; no out_valid for that operand; next operand 4'b1111 -> 4'b1111 with correct latency.
REQ-032 CNT_W=2, 5 handoffs -> ops_done sequence 1,2,3,0,1.
